// File: rtl/axi4_mem_slave_if.sv
// ----------------------------------------------------------------------------
// axi4_mem_slave_if
// Bundles the five AXI4 channels (AW, W, B, AR, R) used by axi4_mem_slave.
//   master modport : drives addresses, write data, bready/rready
//   slave modport  : drives readies, write response and read data
// Clock and reset are not part of the bundle; they stay plain module ports.
// ----------------------------------------------------------------------------
interface axi4_mem_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wlast;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rlast;
    logic                  rready;

    modport master (
        output awaddr, awlen, awsize, awvalid, input awready,
        output wdata, wvalid, wlast, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arlen, arsize, arvalid, input arready,
        input  rdata, rresp, rvalid, rlast, output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awvalid, output awready,
        input  wdata, wvalid, wlast, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arlen, arsize, arvalid, output arready,
        output rdata, rresp, rvalid, rlast, input rready
    );
endinterface

// File: rtl/axi4_mem_slave.sv
// ----------------------------------------------------------------------------
// axi4_mem_slave
// AXI4 slave backed by a single-port MEMORY_DEPTH x DATA_WIDTH word array.
// Serves INCR bursts one at a time, round-robin between AW and AR.
// Bad size or out-of-range bursts complete normally but answer SLVERR,
// never touch the array and return zero read data.
// Ports:
//   aclk   : clock, rising edge
//   areset : synchronous reset, active-high
//   bus    : AXI4 channel bundle (slave modport)
// ----------------------------------------------------------------------------
module axi4_mem_slave #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 1024
) (
    input  logic             aclk,
    input  logic             areset,
    axi4_mem_slave_if.slave  bus
);
    localparam int LANE_BITS = $clog2(DATA_WIDTH / 8);
    localparam int MW        = $clog2(MEMORY_DEPTH);
    localparam int WW        = ADDR_WIDTH - LANE_BITS;

    localparam logic [2:0]    SIZE_OK = 3'(LANE_BITS);
    localparam logic [WW:0]   DEPTH_W = (WW + 1)'(MEMORY_DEPTH);
    localparam logic [MW-1:0] IDX_ONE = {{(MW - 1){1'b0}}, 1'b1};
    localparam logic [1:0]    OKAY    = 2'b00;
    localparam logic [1:0]    SLVERR  = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_WDATA, ST_WRESP, ST_RDATA} state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [DATA_WIDTH-1:0] mem_r [MEMORY_DEPTH];
    logic [MW-1:0]         idx_r;
    logic [7:0]            len_r;
    logic [7:0]            cnt_r;
    logic                  err_r;
    logic                  prio_w_r;
    logic [1:0]            bresp_r;
    logic [1:0]            rresp_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  rvalid_r;

    logic                  grant_w_s;
    logic                  grant_r_s;
    logic                  aw_err_s;
    logic                  ar_err_s;
    logic                  cnt_last_s;
    logic [MW-1:0]         rd_idx_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic                  unused_s;

    // Burst is illegal if the beat size is not the full bus width or its last word falls past the array.
    function automatic logic burst_err(input logic [WW-1:0] widx, input logic [7:0] len,
                                       input logic [2:0] size);
        logic [WW:0] last_v;
        last_v = {1'b0, widx} + {{(WW - 7){1'b0}}, len};
        return (size != SIZE_OK) || (last_v >= DEPTH_W);
    endfunction

    assign aw_err_s   = burst_err(bus.awaddr[ADDR_WIDTH-1:LANE_BITS], bus.awlen, bus.awsize);
    assign ar_err_s   = burst_err(bus.araddr[ADDR_WIDTH-1:LANE_BITS], bus.arlen, bus.arsize);
    assign cnt_last_s = (cnt_r == len_r);
    // Byte-lane address bits carry no meaning for full-width beats.
    assign unused_s   = ^{bus.awaddr[LANE_BITS-1:0], bus.araddr[LANE_BITS-1:0]};

    // prio_w_r breaks the tie when both address channels are valid; at most one grant is ever issued.
    assign grant_w_s = (state_r == ST_IDLE) && bus.awvalid && (!bus.arvalid || prio_w_r);
    assign grant_r_s = (state_r == ST_IDLE) && bus.arvalid && !grant_w_s;

    assign bus.awready = grant_w_s;
    assign bus.arready = grant_r_s;
    assign bus.wready  = (state_r == ST_WDATA);
    assign bus.bvalid  = (state_r == ST_WRESP);
    assign bus.bresp   = bresp_r;
    assign bus.rdata   = rdata_r;
    assign bus.rresp   = rresp_r;
    assign bus.rvalid  = rvalid_r;
    assign bus.rlast   = rvalid_r && cnt_last_s;

    // Read port address: first word of a new burst in IDLE, otherwise the word after the current beat.
    always_comb begin
        rd_idx_s = idx_r + IDX_ONE;
        if (state_r == ST_IDLE) begin
            rd_idx_s = bus.araddr[LANE_BITS +: MW];
        end else begin
            rd_idx_s = idx_r + IDX_ONE;
        end
    end

    assign rd_word_s = mem_r[rd_idx_s];

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_w_s) begin
                    state_nxt_s = ST_WDATA;
                end else if (grant_r_s) begin
                    state_nxt_s = ST_RDATA;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WDATA: begin
                // The beat count, not WLAST, closes the burst.
                if (bus.wvalid && cnt_last_s) begin
                    state_nxt_s = ST_WRESP;
                end else begin
                    state_nxt_s = ST_WDATA;
                end
            end
            ST_WRESP: begin
                if (bus.bready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WRESP;
                end
            end
            ST_RDATA: begin
                if (rvalid_r && bus.rready && cnt_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RDATA;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register plus burst bookkeeping and registered response/read-data outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r  <= ST_IDLE;
            prio_w_r <= 1'b1;
            idx_r    <= '0;
            len_r    <= 8'd0;
            cnt_r    <= 8'd0;
            err_r    <= 1'b0;
            bresp_r  <= OKAY;
            rresp_r  <= OKAY;
            rdata_r  <= '0;
            rvalid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (grant_w_s) begin
                        idx_r    <= bus.awaddr[LANE_BITS +: MW];
                        len_r    <= bus.awlen;
                        cnt_r    <= 8'd0;
                        err_r    <= aw_err_s;
                        bresp_r  <= aw_err_s ? SLVERR : OKAY;
                        prio_w_r <= 1'b0;
                    end else if (grant_r_s) begin
                        idx_r    <= bus.araddr[LANE_BITS +: MW];
                        len_r    <= bus.arlen;
                        cnt_r    <= 8'd0;
                        err_r    <= ar_err_s;
                        rresp_r  <= ar_err_s ? SLVERR : OKAY;
                        rdata_r  <= ar_err_s ? '0 : rd_word_s;
                        rvalid_r <= 1'b1;
                        prio_w_r <= 1'b1;
                    end
                end
                ST_WDATA: begin
                    if (bus.wvalid) begin
                        idx_r <= idx_r + IDX_ONE;
                        cnt_r <= cnt_r + 8'd1;
                        // A WLAST that disagrees with the beat count poisons the response only.
                        if (bus.wlast != cnt_last_s) begin
                            bresp_r <= SLVERR;
                        end
                    end
                end
                ST_WRESP: begin
                    cnt_r <= cnt_r;
                end
                ST_RDATA: begin
                    if (rvalid_r && bus.rready) begin
                        if (cnt_last_s) begin
                            rvalid_r <= 1'b0;
                        end else begin
                            // Preload the next word on the accepting edge so beats stream without a bubble.
                            idx_r   <= idx_r + IDX_ONE;
                            cnt_r   <= cnt_r + 8'd1;
                            rdata_r <= err_r ? '0 : rd_word_s;
                        end
                    end
                end
                default: begin
                    rvalid_r <= 1'b0;
                end
            endcase
        end
    end

    // Array write port; a beat coinciding with reset is dropped.
    always_ff @(posedge aclk) begin
        if (!areset && (state_r == ST_WDATA) && bus.wvalid && !err_r) begin
            mem_r[idx_r] <= bus.wdata;
        end
    end
endmodule

// File: tb/tb_axi4_mem_slave.sv
// ----------------------------------------------------------------------------
// tb_axi4_mem_slave
// Directed bench for axi4_mem_slave. Driver tasks push expected B and R
// responses into queues; a negedge monitor pops and compares them whenever
// the DUT completes a handshake, and also checks ready exclusivity, stall
// stability and grant order.
// ----------------------------------------------------------------------------
module tb_axi4_mem_slave;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam byte        GW     = 8'h57;
    localparam byte        GR     = 8'h52;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    logic clk;
    logic areset;

    axi4_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    axi4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEMORY_DEPTH(1024)) dut (
        .aclk   (clk),
        .areset (areset),
        .bus    (bus)
    );

    int          n_checks = 0;
    int          n_err    = 0;
    logic [1:0]  exp_b_q [$];
    rexp_t       exp_r_q [$];
    byte         grant_log [$];
    logic [31:0] wbuf [8];
    logic [31:0] rbuf [8];
    logic        rpat [4];

    logic        hold_v;
    logic [34:0] hold_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on B/R handshakes plus protocol properties.
    always @(negedge clk) begin
        rexp_t e;
        logic [1:0] eb;
        if (bus.awready || bus.arready)
            chk("ready_exclusive", 64'(bus.awready & bus.arready), 64'd0);
        if (bus.awready) grant_log.push_back(GW);
        if (bus.arready) grant_log.push_back(GR);
        if (bus.bvalid && bus.bready) begin
            if (exp_b_q.size() == 0) begin
                chk("b_unexpected", 64'(bus.bresp), 64'hDEAD);
            end else begin
                eb = exp_b_q.pop_front();
                chk("bresp", 64'(bus.bresp), 64'(eb));
            end
        end
        if (bus.rvalid && hold_v)
            chk("r_stall_hold", 64'({bus.rdata, bus.rresp, bus.rlast}), 64'(hold_val));
        if (bus.rvalid && bus.rready) begin
            if (exp_r_q.size() == 0) begin
                chk("r_unexpected", 64'(bus.rdata), 64'hDEAD);
            end else begin
                e = exp_r_q.pop_front();
                chk("r_beat{data,resp,last}", 64'({bus.rdata, bus.rresp, bus.rlast}), 64'(e));
            end
        end
        hold_v   = bus.rvalid && !bus.rready;
        hold_val = {bus.rdata, bus.rresp, bus.rlast};
    end

    task automatic wait_aw();
        int t = 0;
        @(negedge clk);
        while (!bus.awready && t < 50) begin @(negedge clk); t++; end
        chk("aw_accept", 64'(bus.awready), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_ar();
        int t = 0;
        @(negedge clk);
        while (!bus.arready && t < 50) begin @(negedge clk); t++; end
        chk("ar_accept", 64'(bus.arready), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_w();
        int t = 0;
        @(negedge clk);
        while (!bus.wready && t < 20) begin @(negedge clk); t++; end
        chk("w_accept", 64'(bus.wready), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_b();
        int t = 0;
        while (exp_b_q.size() != 0 && t < 20) begin @(posedge clk); #1; t++; end
        chk("b_drain", 64'(exp_b_q.size()), 64'd0);
    endtask

    // Write burst of len+1 beats from wbuf; WLAST is driven on beat last_at.
    task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input int last_at, input logic [1:0] exp);
        exp_b_q.push_back(exp);
        bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awvalid = 1'b1;
        wait_aw();
        bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.wdata = wbuf[i]; bus.wlast = (i == last_at); bus.wvalid = 1'b1;
            wait_w();
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
    endtask

    // Read burst expecting rbuf[0..len] with response resp; rready follows rpat.
    task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] resp);
        int k = 0;
        for (int i = 0; i <= int'(len); i++) exp_r_q.push_back({rbuf[i], resp, (i == int'(len))});
        bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arvalid = 1'b1;
        wait_ar();
        bus.arvalid = 1'b0;
        chk("r_latency", 64'(bus.rvalid), 64'd1);
        while (exp_r_q.size() != 0 && k < 100) begin
            bus.rready = rpat[k % 4];
            @(posedge clk); #1;
            k++;
        end
        bus.rready = 1'b1;
        chk("r_drain", 64'(exp_r_q.size()), 64'd0);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk(nm, 64'({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.bresp,
                      bus.rvalid, bus.rlast, bus.rresp, bus.rdata}), 64'd0);
    endtask

    initial begin
        areset = 1'b1;
        bus.awaddr = '0; bus.awlen = 8'd0; bus.awsize = 3'd2; bus.awvalid = 1'b0;
        bus.wdata = 32'd0; bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
        bus.araddr = '0; bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        hold_v = 1'b0; hold_val = '0;
        for (int i = 0; i < 4; i++) rpat[i] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset_outputs");
        areset = 1'b0;
        @(posedge clk); #1;

        // Basic 4-beat write then read-back.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
        do_write(16'h0010, 8'd3, 3'd2, 3, OKAY);
        wait_b();
        for (int i = 0; i < 4; i++) rbuf[i] = 32'hA0 + 32'(i);
        do_read(16'h0010, 8'd3, 3'd2, OKAY);

        // Simultaneous AW/AR twice: write wins first, then read, then the pending write.
        grant_log.delete();
        bus.araddr = 16'h0010; bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arvalid = 1'b1;
        wbuf[0] = 32'h11;
        do_write(16'h0040, 8'd0, 3'd2, 0, OKAY);
        bus.awaddr = 16'h0044; bus.awlen = 8'd0; bus.awsize = 3'd2; bus.awvalid = 1'b1;
        rbuf[0] = 32'hA0;
        do_read(16'h0010, 8'd0, 3'd2, OKAY);
        wbuf[0] = 32'h22;
        do_write(16'h0044, 8'd0, 3'd2, 0, OKAY);
        wait_b();
        chk("grant_count", 64'(grant_log.size()), 64'd3);
        if (grant_log.size() == 3) begin
            chk("grant0", 64'(grant_log[0]), 64'(GW));
            chk("grant1", 64'(grant_log[1]), 64'(GR));
            chk("grant2", 64'(grant_log[2]), 64'(GW));
        end
        rbuf[0] = 32'h11; rbuf[1] = 32'h22;
        do_read(16'h0040, 8'd1, 3'd2, OKAY);

        // Top-of-array boundary: 1020+3 is legal, 1020+7 is a range error.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0 + 32'(i);
        do_write(16'h0FF0, 8'd3, 3'd2, 3, OKAY);
        wait_b();
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hEE00 + 32'(i);
        do_write(16'h0FF0, 8'd7, 3'd2, 7, SLVERR);
        wait_b();
        for (int i = 0; i < 4; i++) rbuf[i] = 32'hC0 + 32'(i);
        do_read(16'h0FF0, 8'd3, 3'd2, OKAY);
        for (int i = 0; i < 8; i++) rbuf[i] = 32'd0;
        do_read(16'h0FF0, 8'd7, 3'd2, SLVERR);

        // Size errors on both channels.
        wbuf[0] = 32'h5A5A;
        do_write(16'h0300, 8'd0, 3'd1, 0, SLVERR);
        wait_b();
        do_read(16'h0010, 8'd1, 3'd1, SLVERR);

        // Stalled read: rready 1,0,0,1.
        rpat[0] = 1'b1; rpat[1] = 1'b0; rpat[2] = 1'b0; rpat[3] = 1'b1;
        for (int i = 0; i < 4; i++) rbuf[i] = 32'hA0 + 32'(i);
        do_read(16'h0010, 8'd3, 3'd2, OKAY);
        for (int i = 0; i < 4; i++) rpat[i] = 1'b1;

        // Early WLAST: three beats still taken, data kept, SLVERR reported.
        for (int i = 0; i < 3; i++) wbuf[i] = 32'hD0 + 32'(i);
        do_write(16'h0100, 8'd2, 3'd2, 1, SLVERR);
        wait_b();
        for (int i = 0; i < 3; i++) rbuf[i] = 32'hD0 + 32'(i);
        do_read(16'h0100, 8'd2, 3'd2, OKAY);

        // Reset during beat 2 of a 4-beat write.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hF0 + 32'(i);
        do_write(16'h0200, 8'd3, 3'd2, 3, OKAY);
        wait_b();
        bus.awaddr = 16'h0200; bus.awlen = 8'd3; bus.awsize = 3'd2; bus.awvalid = 1'b1;
        wait_aw();
        bus.awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.wdata = 32'hB0 + 32'(i); bus.wlast = 1'b0; bus.wvalid = 1'b1;
            wait_w();
        end
        bus.wdata = 32'hB2; bus.wvalid = 1'b1; areset = 1'b1;
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        chk_outputs_zero("reset_midburst_outputs");
        areset = 1'b0;
        @(posedge clk); #1;
        rbuf[0] = 32'hB0; rbuf[1] = 32'hB1; rbuf[2] = 32'hF2; rbuf[3] = 32'hF3;
        do_read(16'h0200, 8'd3, 3'd2, OKAY);

        repeat (3) @(posedge clk);
        chk("final_b_queue", 64'(exp_b_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
